// File: rtl/tlc_pkg.sv
// Shared types for the traffic conflict monitor: approach phases, FSM states,
// fault codes and small phase helpers used by the tracker and the top level.
package tlc_pkg;

  typedef enum logic [1:0] {
    PH_R   = 2'd0,
    PH_Y   = 2'd1,
    PH_G   = 2'd2,
    PH_INV = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam logic [2:0] FC_NONE         = 3'd0;
  localparam logic [2:0] FC_CONFLICT     = 3'd1;
  localparam logic [2:0] FC_LAMP         = 3'd2;
  localparam logic [2:0] FC_SEQ          = 3'd3;
  localparam logic [2:0] FC_SHORT_YELLOW = 3'd4;
  localparam logic [2:0] FC_SHORT_GREEN  = 3'd5;

  localparam int NUM_APPR = 2;

  // Lamp triple is packed {red, yellow, green}; anything but one-hot is INV.
  function automatic phase_e decode_phase(input logic [2:0] rgb);
    phase_e ph;
    case (rgb)
      3'b100:  ph = PH_R;
      3'b010:  ph = PH_Y;
      3'b001:  ph = PH_G;
      default: ph = PH_INV;
    endcase
    return ph;
  endfunction

  function automatic logic is_go(input phase_e ph);
    return (ph == PH_Y) || (ph == PH_G);
  endfunction

  function automatic logic is_legal_step(input phase_e from_ph, input phase_e to_ph);
    return ((from_ph == PH_R) && (to_ph == PH_G)) ||
           ((from_ph == PH_G) && (to_ph == PH_Y)) ||
           ((from_ph == PH_Y) && (to_ph == PH_R));
  endfunction

endpackage

// File: rtl/tlc_phase_tracker.sv
// One approach: decode the registered lamp triple, debounce it into a stable
// phase, time each stable phase and flag illegal or too-short transitions.
module tlc_phase_tracker
  import tlc_pkg::*;
#(
  parameter int FILTER     = 2,
  parameter int MIN_GREEN  = 16,
  parameter int MIN_YELLOW = 4,
  parameter int CNT_W      = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_run,
  input  logic [2:0] i_lamps,
  output phase_e     o_decoded,
  output phase_e     o_stable,
  output logic       o_seq_err,
  output logic       o_short_green,
  output logic       o_short_yellow
);

  localparam logic [2:0]       FILT     = 3'(FILTER);
  localparam logic [CNT_W-1:0] MIN_G    = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MIN_Y    = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] DUR_MAX  = '1;

  phase_e           r_stable;
  phase_e           r_cand;
  logic [2:0]       r_run_cnt;
  logic [CNT_W-1:0] r_dur;
  logic             r_full;

  phase_e     w_dec;
  logic       w_hit;
  logic [2:0] w_run_next;
  logic       w_upd;
  logic       w_check;

  always_comb begin
    w_dec      = decode_phase(i_lamps);
    // A stable of PH_INV means "no stable phase yet"; INV itself never qualifies.
    w_hit      = (w_dec != PH_INV) && (w_dec != r_stable);
    w_run_next = ((w_dec == r_cand) && (r_run_cnt != 3'd0)) ? r_run_cnt + 3'd1 : 3'd1;
    w_upd      = w_hit && (w_run_next >= FILT);
    w_check    = i_run && w_upd && (r_stable != PH_INV);
  end

  assign o_decoded      = w_dec;
  assign o_stable       = r_stable;
  assign o_seq_err      = w_check && !is_legal_step(r_stable, w_dec);
  // r_full stays low for the phase that was already running when RUN began.
  assign o_short_green  = w_check && r_full && (r_stable == PH_G) && (w_dec == PH_Y) && (r_dur < MIN_G);
  assign o_short_yellow = w_check && r_full && (r_stable == PH_Y) && (w_dec == PH_R) && (r_dur < MIN_Y);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stable  <= PH_INV;
      r_cand    <= PH_INV;
      r_run_cnt <= 3'd0;
      r_dur     <= '0;
      r_full    <= 1'b0;
    end else if (i_clr) begin
      r_stable  <= PH_INV;
      r_cand    <= PH_INV;
      r_run_cnt <= 3'd0;
      r_dur     <= '0;
      r_full    <= 1'b0;
    end else begin
      if (w_upd) begin
        r_stable  <= w_dec;
        r_run_cnt <= 3'd0;
        r_dur     <= '0;
      end else begin
        if (w_hit) begin
          r_cand    <= w_dec;
          r_run_cnt <= w_run_next;
        end else begin
          r_run_cnt <= 3'd0;
        end
        if (r_dur != DUR_MAX) begin
          r_dur <= r_dur + 1'b1;
        end
      end
      r_full <= i_run && (r_full || w_upd);
    end
  end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Lamp-side safety monitor: registers the six lamp drives, tracks NS/EW phases,
// detects conflicts and lamp faults, and latches the first fault into flash mode.
module traffic_conflict_monitor
  import tlc_pkg::*;
#(
  parameter int FILTER     = 2,
  parameter int MIN_GREEN  = 16,
  parameter int MIN_YELLOW = 4,
  parameter int CNT_W      = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_NS_red,
  input  logic       i_NS_yellow,
  input  logic       i_NS_green,
  input  logic       i_EW_red,
  input  logic       i_EW_yellow,
  input  logic       i_EW_green,
  input  logic       i_clear,
  output logic       o_fault,
  output logic [2:0] o_fault_code,
  output logic       o_fault_src,
  output logic       o_flash,
  output logic       o_running
);

  localparam logic [2:0] FILT_M1 = 3'(FILTER - 1);

  // Index 0 is NS, index 1 is EW; each entry is {red, yellow, green}.
  logic [NUM_APPR-1:0][2:0] r_lamps;
  logic [2:0]               r_conf_cnt;
  state_e                   r_state;
  logic                     r_fault;
  logic [2:0]               r_code;
  logic                     r_src;
  logic                     r_running;

  phase_e              w_dec    [NUM_APPR];
  phase_e              w_stable [NUM_APPR];
  logic [NUM_APPR-1:0] w_inv_det;
  logic [NUM_APPR-1:0] w_seq_err;
  logic [NUM_APPR-1:0] w_short_green;
  logic [NUM_APPR-1:0] w_short_yellow;
  logic                w_run;
  logic                w_clr;
  logic                w_conf_now;
  logic                w_conf_det;
  logic [2:0]          w_code;
  logic                w_src;

  assign w_run = (r_state == ST_RUN);
  assign w_clr = (r_state == ST_FAULT) && i_clear;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lamps <= '0;
    end else begin
      r_lamps <= {{i_EW_red, i_EW_yellow, i_EW_green}, {i_NS_red, i_NS_yellow, i_NS_green}};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_APPR; gi++) begin : g_appr
      logic [2:0] r_inv_cnt;

      tlc_phase_tracker #(
        .FILTER     (FILTER),
        .MIN_GREEN  (MIN_GREEN),
        .MIN_YELLOW (MIN_YELLOW),
        .CNT_W      (CNT_W)
      ) u_trk (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_clr          (w_clr),
        .i_run          (w_run),
        .i_lamps        (r_lamps[gi]),
        .o_decoded      (w_dec[gi]),
        .o_stable       (w_stable[gi]),
        .o_seq_err      (w_seq_err[gi]),
        .o_short_green  (w_short_green[gi]),
        .o_short_yellow (w_short_yellow[gi])
      );

      assign w_inv_det[gi] = (w_dec[gi] == PH_INV) && (r_inv_cnt >= FILT_M1);

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_inv_cnt <= 3'd0;
        end else if (w_clr || (w_dec[gi] != PH_INV)) begin
          r_inv_cnt <= 3'd0;
        end else if (!w_inv_det[gi]) begin
          r_inv_cnt <= r_inv_cnt + 3'd1;
        end
      end
    end
  endgenerate

  // Persistence counters saturate one short of FILTER so detection fires on
  // the FILTER-th consecutive sample and keeps firing while it persists.
  assign w_conf_now = is_go(w_dec[0]) && is_go(w_dec[1]);
  assign w_conf_det = w_conf_now && (r_conf_cnt >= FILT_M1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_conf_cnt <= 3'd0;
    end else if (w_clr || !w_conf_now) begin
      r_conf_cnt <= 3'd0;
    end else if (!w_conf_det) begin
      r_conf_cnt <= r_conf_cnt + 3'd1;
    end
  end

  always_comb begin
    w_code = FC_NONE;
    w_src  = 1'b0;
    if (w_conf_det) begin
      w_code = FC_CONFLICT;
    end else if (|w_inv_det) begin
      w_code = FC_LAMP;
      w_src  = !w_inv_det[0];
    end else if (|w_seq_err) begin
      w_code = FC_SEQ;
      w_src  = !w_seq_err[0];
    end else if (|w_short_yellow) begin
      w_code = FC_SHORT_YELLOW;
      w_src  = !w_short_yellow[0];
    end else if (|w_short_green) begin
      w_code = FC_SHORT_GREEN;
      w_src  = !w_short_green[0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_INIT;
      r_fault   <= 1'b0;
      r_code    <= FC_NONE;
      r_src     <= 1'b0;
      r_running <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (w_code != FC_NONE) begin
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
            r_code  <= w_code;
            r_src   <= w_src;
          end else if ((w_stable[0] != PH_INV) && (w_stable[1] != PH_INV)) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_code != FC_NONE) begin
            r_state   <= ST_FAULT;
            r_fault   <= 1'b1;
            r_code    <= w_code;
            r_src     <= w_src;
            r_running <= 1'b0;
          end
        end
        ST_FAULT: begin
          if (i_clear) begin
            r_state <= ST_INIT;
            r_fault <= 1'b0;
            r_code  <= FC_NONE;
            r_src   <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_INIT;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign o_fault      = r_fault;
  assign o_flash      = r_fault;
  assign o_fault_code = r_code;
  assign o_fault_src  = r_src;
  assign o_running    = r_running;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Bench for traffic_conflict_monitor: directed test-plan scenarios followed by
// random lamp traffic, every cycle compared against a window-based reference model.
module tb_traffic_conflict_monitor;

  localparam int FILTER     = 2;
  localparam int MIN_GREEN  = 16;
  localparam int MIN_YELLOW = 4;
  localparam int SAT        = 255;

  localparam int R = 0, Y = 1, G = 2, X = 3;
  localparam int M_INIT = 0, M_RUN = 1, M_FAULT = 2;

  // Lamp vector layout: {NS r,y,g, EW r,y,g}
  localparam logic [5:0] NORM_NG = 6'b001_100;
  localparam logic [5:0] NORM_NY = 6'b010_100;
  localparam logic [5:0] NORM_EG = 6'b100_001;
  localparam logic [5:0] NORM_EY = 6'b100_010;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] lamps;
  logic       clear;
  logic       o_fault, o_flash, o_running, o_src;
  logic [2:0] o_code;

  traffic_conflict_monitor #(
    .FILTER(FILTER), .MIN_GREEN(MIN_GREEN), .MIN_YELLOW(MIN_YELLOW), .CNT_W(8)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_NS_red     (lamps[5]),
    .i_NS_yellow  (lamps[4]),
    .i_NS_green   (lamps[3]),
    .i_EW_red     (lamps[2]),
    .i_EW_yellow  (lamps[1]),
    .i_EW_green   (lamps[0]),
    .i_clear      (clear),
    .o_fault      (o_fault),
    .o_fault_code (o_code),
    .o_fault_src  (o_src),
    .o_flash      (o_flash),
    .o_running    (o_running)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         hn[$];
  int         he[$];
  int         stab  [2];
  int         lastu [2];
  bit         part  [2];
  int         mode;
  int         e_fault, e_code, e_src, e_run;
  int         ecount = 0;
  logic [5:0] mreg;
  bit         rnd_clr_en = 1'b0;

  task automatic check(input string tag, input logic [7:0] got, input int want);
    total++;
    if (got !== 8'(want)) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic int dec3(input logic [2:0] rgb);
    if (rgb == 3'b100) return R;
    if (rgb == 3'b010) return Y;
    if (rgb == 3'b001) return G;
    return X;
  endfunction

  function automatic bit go(input int p);
    return (p == Y) || (p == G);
  endfunction

  // Value shared by the whole FILTER-long window, or -1 if it is not uniform.
  function automatic int steady(input int q[$]);
    if (q.size() < FILTER) return -1;
    for (int i = 1; i < q.size(); i++) if (q[i] != q[0]) return -1;
    return q[0];
  endfunction

  task automatic model_reset();
    hn.delete();
    he.delete();
    for (int a = 0; a < 2; a++) begin
      stab[a]  = X;
      lastu[a] = ecount;
      part[a]  = 1'b1;
    end
    mode = M_INIT;
    e_fault = 0; e_code = 0; e_src = 0; e_run = 0;
    mreg = 6'd0;
  endtask

  task automatic model_edge(input logic [5:0] cur, input logic clr);
    int v[2];
    bit upd[2], seqe[2], sg[2], sy[2];
    bit conf, both_valid;
    int code, src, dur, old_mode;
    ecount++;
    old_mode = mode;
    if (mode == M_FAULT && clr) begin
      hn.delete();
      he.delete();
      for (int a = 0; a < 2; a++) begin
        stab[a] = X; lastu[a] = ecount; part[a] = 1'b1;
      end
      mode = M_INIT;
      e_fault = 0; e_code = 0; e_src = 0;
    end else begin
      hn.push_back(dec3(mreg[5:3]));
      he.push_back(dec3(mreg[2:0]));
      if (hn.size() > FILTER) void'(hn.pop_front());
      if (he.size() > FILTER) void'(he.pop_front());
      conf = (hn.size() == FILTER);
      for (int i = 0; i < hn.size(); i++) if (!(go(hn[i]) && go(he[i]))) conf = 1'b0;
      v[0] = steady(hn);
      v[1] = steady(he);
      for (int a = 0; a < 2; a++) begin
        upd[a] = (v[a] >= 0) && (v[a] != X) && (v[a] != stab[a]);
        seqe[a] = 1'b0; sg[a] = 1'b0; sy[a] = 1'b0;
        if (upd[a] && mode == M_RUN) begin
          dur = ecount - lastu[a] - 1;
          if (dur > SAT) dur = SAT;
          seqe[a] = !((stab[a] == R && v[a] == G) || (stab[a] == G && v[a] == Y) ||
                      (stab[a] == Y && v[a] == R));
          sg[a] = !part[a] && stab[a] == G && v[a] == Y && dur < MIN_GREEN;
          sy[a] = !part[a] && stab[a] == Y && v[a] == R && dur < MIN_YELLOW;
        end
      end
      code = 0; src = 0;
      if (mode != M_FAULT) begin
        if (conf)                 code = 1;
        else if (v[0] == X)       code = 2;
        else if (v[1] == X)       begin code = 2; src = 1; end
        else if (seqe[0])         code = 3;
        else if (seqe[1])         begin code = 3; src = 1; end
        else if (sy[0])           code = 4;
        else if (sy[1])           begin code = 4; src = 1; end
        else if (sg[0])           code = 5;
        else if (sg[1])           begin code = 5; src = 1; end
      end
      both_valid = (stab[0] != X) && (stab[1] != X);
      if (code != 0) begin
        mode = M_FAULT; e_fault = 1; e_code = code; e_src = src; e_run = 0;
      end else if (mode == M_INIT && both_valid) begin
        mode = M_RUN; e_run = 1;
      end
      for (int a = 0; a < 2; a++) begin
        if (old_mode != M_RUN) part[a] = 1'b1;
        else if (upd[a])       part[a] = 1'b0;
        if (upd[a]) begin
          stab[a] = v[a]; lastu[a] = ecount;
        end
      end
    end
    mreg = cur;
  endtask

  task automatic step(input logic [5:0] b, input logic clr);
    lamps = b;
    clear = clr;
    @(posedge clk);
    model_edge(b, clr);
    #1;
    check("fault", 8'(o_fault), e_fault);
    check("code", 8'(o_code), e_code);
    check("src", 8'(o_src), e_src);
    check("flash", 8'(o_flash), e_fault);
    check("running", 8'(o_running), e_run);
    clear = 1'b0;
  endtask

  task automatic seg(input logic [5:0] b, input int n);
    $display("seg lamps=%b len=%0d mode=%0d fault=%0d code=%0d", b, n, mode, o_fault, o_code);
    for (int i = 0; i < n; i++) step(b, rnd_clr_en && ($urandom_range(0, 63) == 0));
  endtask

  logic [5:0] pat [4];
  int k;
  int r;
  int start;

  initial begin
    pat = '{NORM_NG, NORM_NY, NORM_EG, NORM_EY};
    rst = 1'b1;
    lamps = NORM_NG;
    clear = 1'b0;
    model_reset();
    #1;
    check("rst_fault", 8'(o_fault), 0);
    check("rst_code", 8'(o_code), 0);
    check("rst_src", 8'(o_src), 0);
    check("rst_flash", 8'(o_flash), 0);
    check("rst_running", 8'(o_running), 0);
    #19 rst = 1'b0;

    // Three full legal cycles with default timings.
    for (int c = 0; c < 3; c++) begin
      seg(NORM_NG, 20); seg(NORM_NY, 5); seg(NORM_EG, 20); seg(NORM_EY, 5);
    end
    check("normal_fault", 8'(o_fault), 0);
    check("normal_run", 8'(o_running), 1);

    // Clear outside FAULT is ignored; a one-cycle EW green is filtered out.
    step(NORM_NG, 1'b1);
    seg(NORM_NG, 19);
    check("clear_in_run", 8'(o_running), 1);
    seg(6'b001_001, 1);
    seg(NORM_NG, 4);
    check("glitch", 8'(o_fault), 0);

    // Conflict: fault appears FILTER+1 edges after application.
    seg(6'b001_001, 2);
    check("conf_early", 8'(o_fault), 0);
    seg(6'b001_001, 1);
    check("conf_fault", 8'(o_fault), 1);
    check("conf_code", 8'(o_code), 1);
    check("conf_src", 8'(o_src), 0);
    check("conf_flash", 8'(o_flash), 1);
    seg(6'b001_000, 3);
    check("latch_code", 8'(o_code), 1);

    step(NORM_NG, 1'b1);
    check("clr_fault", 8'(o_fault), 0);
    seg(NORM_NG, 6);
    check("reinit_run", 8'(o_running), 1);

    // Lamp fault on EW (red+green), then async reset while faulted.
    seg(6'b001_000 | 6'b000_101, 3);
    check("lamp_code", 8'(o_code), 2);
    check("lamp_src", 8'(o_src), 1);
    #3 rst = 1'b1;
    #1;
    check("arst_fault", 8'(o_fault), 0);
    check("arst_code", 8'(o_code), 0);
    check("arst_src", 8'(o_src), 0);
    check("arst_flash", 8'(o_flash), 0);
    check("arst_running", 8'(o_running), 0);
    model_reset();
    @(posedge clk);
    #5 rst = 1'b0;

    // Random traffic: mostly legal steps with random timing, plus skips,
    // garbage patterns, overlapping greens and stray clears.
    rnd_clr_en = 1'b1;
    k = 0;
    start = ecount;
    while (ecount - start < 3000) begin
      if (mode == M_FAULT) begin
        seg(lamps, $urandom_range(1, 4));
        step(pat[k], 1'b1);
      end else begin
        r = $urandom_range(0, 15);
        if (r == 0) begin
          seg(6'($urandom), $urandom_range(1, 3));
        end else if (r == 1) begin
          k = (k + 1) % 4;
        end else if (r == 2) begin
          seg(($urandom_range(0, 1) == 1) ? 6'b001_010 : 6'b010_001, $urandom_range(1, 3));
        end else begin
          seg(pat[k], (k % 2 == 0) ? $urandom_range(12, 26) : $urandom_range(1, 7));
          k = (k + 1) % 4;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
